// File: rtl/addr_hash_sched.sv
// rtl/addr_hash_sched.sv - round-robin front end and reconfigurable 2-stage multiplicative address hash
module addr_hash_sched #(
    parameter int ADDR_WIDTH     = 64,
    parameter int NUM_REQ        = 4,
    parameter int MAX_LG_BUCKETS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [MAX_LG_BUCKETS-1:0]     resp_bucket,
    input  logic                          cfg_valid,
    input  logic [31:0]                   cfg_num_buckets,
    input  logic [ADDR_WIDTH/2-1:0]       cfg_coe_a,
    input  logic [ADDR_WIDTH/2-1:0]       cfg_coe_b,
    output logic                          cfg_ready,
    output logic                          cfg_err,
    output logic                          busy
);
    localparam int H    = ADDR_WIDTH / 2;
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int LG_W = $clog2(MAX_LG_BUCKETS + 1);
    localparam logic [63:0] MAX_N = 64'd1 << MAX_LG_BUCKETS;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

    state_t            state, state_nxt;
    logic              grant_en;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     rr_sum;
    logic [ID_W-1:0]   rr_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic              xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [H-1:0]      prod_a, prod_b;

    logic [LG_W-1:0]   lg_num_buckets;
    logic [H-1:0]      coe_a, coe_b;
    logic              cfg_legal;
    logic [LG_W-1:0]   cfg_lg;

    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic [H-1:0]      s1_pa, s1_pb;
    logic [H-1:0]      hash_sum;
    logic [MAX_LG_BUCKETS-1:0] bucket_nxt;
    int                shamt;

    // Round-robin search starting at rr_ptr; rr_sum is wide enough to wrap without overflow.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (rr_sum >= (ID_W+1)'(NUM_REQ))
                rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
            rr_idx = rr_sum[ID_W-1:0];
            if (!grant_any && req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_en && grant_any)
            req_ready = NUM_REQ'(1) << grant_idx;
    end

    assign xfer = grant_en && grant_any;

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx)
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign prod_a = coe_a * sel_addr[ADDR_WIDTH-1:H];
    assign prod_b = coe_b * sel_addr[H-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_pa    <= '0;
            s1_pb    <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_id <= grant_idx;
                s1_pa <= prod_a;
                s1_pb <= prod_b;
            end
        end
    end

    // lg_num_buckets is stable here: it only changes in LOAD, after both stages are empty.
    always_comb begin
        hash_sum   = s1_pa + s1_pb;
        shamt      = H - int'(lg_num_buckets);
        bucket_nxt = '0;
        if (lg_num_buckets != '0)
            bucket_nxt = MAX_LG_BUCKETS'(hash_sum >> shamt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_bucket <= '0;
        end else begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_id     <= s1_id;
                resp_bucket <= bucket_nxt;
            end
        end
    end

    always_comb begin
        cfg_legal = (cfg_num_buckets != 32'd0) &&
                    ((cfg_num_buckets & (cfg_num_buckets - 32'd1)) == 32'd0) &&
                    ({32'd0, cfg_num_buckets} <= MAX_N);
        cfg_lg = '0;
        for (int i = 0; i < 32; i++) begin
            if (cfg_num_buckets[i])
                cfg_lg = LG_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lg_num_buckets <= '0;
            coe_a          <= H'(32'h9E3779B1);
            coe_b          <= H'(32'h85EBCA77);
        end else if (state == ST_LOAD && cfg_legal) begin
            lg_num_buckets <= cfg_lg;
            coe_a          <= cfg_coe_a;
            coe_b          <= cfg_coe_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (cfg_valid) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !resp_valid) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        grant_en  = (state == ST_RUN) && !cfg_valid;
        cfg_ready = (state == ST_LOAD);
        cfg_err   = (state == ST_LOAD) && !cfg_legal;
        busy      = (state != ST_RUN) || s1_valid || resp_valid;
    end
endmodule
